// File: rtl/cache_fill_if.sv
// Handshake bundle between the CPU/memory side (master) and the cache fill FSM (slave).
interface cache_fill_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] write_word_addr;
  logic        write_tag_array;

  modport master (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, mem_req, memory_address,
    input  write_data_array, write_word_addr, write_tag_array
  );

  modport slave (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, mem_req, memory_address,
    output write_data_array, write_word_addr, write_tag_array
  );
endinterface

// File: rtl/cache_fill.sv
// The fill controller itself is cache_fill_fsm in rtl/cache_fill_fsm.sv.
module cache_fill_unused_stub;
endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: issues one word request per cycle, writes returned words, then the tag.
// Define CACHE_FILL_CRITICAL_FIRST_EN to fetch the missing word first and wrap within the block.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_fill_if.slave  bus
);

  localparam int L  = $clog2(WORDS_PER_BLOCK);
  localparam int CW = L + 1;
  localparam logic [CW-1:0] FULL = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [15:L+1]   r_base_hi;
  logic [CW-1:0]   r_issue_cnt;
  logic [CW-1:0]   r_recv_cnt;
  logic [L-1:0]    w_rot;
  logic [CW-1:0]   w_issue_idx;
  logic            w_start;
  logic            w_issue;
  logic            w_write;
  logic            w_tag;

  // Word offsets are L bits wide, so base+offset can never carry out of the block.
  function automatic logic [L-1:0] order(input logic [CW-1:0] n, input logic [L-1:0] rot);
    return n[L-1:0] + rot;
  endfunction

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  logic [L-1:0] r_miss_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_miss_word <= '0;
    else if (w_start) r_miss_word <= bus.miss_address[L:1];
  end

  assign w_rot = r_miss_word;
`else
  assign w_rot = '0;
`endif

  assign w_start     = (r_state == IDLE) && bus.miss_detected;
  assign w_issue     = (r_state == FILL) && (r_issue_cnt < FULL);
  assign w_write     = (r_state == FILL) && bus.memory_data_valid && (r_recv_cnt < FULL);
  assign w_tag       = w_write && (r_recv_cnt == LAST);
  // Once all requests are out the address parks on the last one issued.
  assign w_issue_idx = (r_issue_cnt < FULL) ? r_issue_cnt : LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.miss_detected) w_next_state = FILL;
      FILL:    if (w_tag)             w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.fsm_busy         = (r_state == FILL);
    bus.mem_req          = w_issue;
    bus.memory_address   = {r_base_hi, order(w_issue_idx, w_rot), 1'b0};
    bus.write_data_array = w_write;
    bus.write_word_addr  = {r_base_hi, order(r_recv_cnt, w_rot), 1'b0};
    bus.write_tag_array  = w_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_hi   <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (w_start) begin
      r_base_hi   <= bus.miss_address[15:L+1];
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      if (w_issue) r_issue_cnt <= r_issue_cnt + CW'(1);
      if (w_write) r_recv_cnt  <= r_recv_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized directed bench for cache_fill_fsm against a schedule-based reference model.
module tb_cache_fill_fsm;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cache_fill_if bus ();

  cache_fill_fsm #(.WORDS_PER_BLOCK(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Address of the n-th word of the fill started by a miss at a.
  function automatic logic [15:0] m_addr(input logic [15:0] a, input int n);
    int base;
    int mw;
    int off;
    base = int'(a) & ~(2 * W - 1);
    mw   = (int'(a) >> 1) % W;
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    off  = (mw + n) % W;
`else
    off  = n % W + 0 * mw;
`endif
    return 16'(base + 2 * off);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  16'(bus.fsm_busy), 16'h0);
    check({tag, "_req"},   16'(bus.mem_req), 16'h0);
    check({tag, "_maddr"}, bus.memory_address, 16'h0);
    check({tag, "_wda"},   16'(bus.write_data_array), 16'h0);
    check({tag, "_waddr"}, bus.write_word_addr, 16'h0);
    check({tag, "_wta"},   16'(bus.write_tag_array), 16'h0);
  endtask

  task automatic idle_cycles(input int n, input bit force_valid);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.miss_detected     = 1'b0;
      bus.miss_address      = 16'($urandom);
      bus.memory_data_valid = force_valid | 1'($urandom);
      #1;
      check("idle_busy", 16'(bus.fsm_busy), 16'h0);
      check("idle_req",  16'(bus.mem_req), 16'h0);
      check("idle_wda",  16'(bus.write_data_array), 16'h0);
      check("idle_wta",  16'(bus.write_tag_array), 16'h0);
    end
  endtask

  // lat > 0: fixed latency; lat == 0: random in-order latency.
  // mode 0: miss only at start; 1: random misses in the fill and one at the tag cycle; 2: miss held high.
  // stop > 0: leave after the cycle carrying response number 'stop'.
  task automatic run_fill(input logic [15:0] a, input int lat, input int mode, input int stop,
                          output int busy_cnt, output logic [15:0] first_req,
                          output logic [15:0] last_req);
    int r [W+1];
    int kat [64];
    int rlast;
    bit exp_wr;
    r[0] = 0;
    for (int c = 0; c < 64; c++) kat[c] = -1;
    for (int k = 1; k <= W; k++) begin
      r[k] = k + ((lat > 0) ? lat : int'($urandom_range(1, 5)));
      if (r[k] <= r[k-1]) r[k] = r[k-1] + 1;
      kat[r[k]] = k - 1;
    end
    rlast     = r[W];
    busy_cnt  = 0;
    first_req = 16'h0;
    last_req  = 16'h0;
    for (int c = 0; c <= rlast; c++) begin
      @(negedge clk);
      case (mode)
        0:       bus.miss_detected = (c == 0);
        1:       bus.miss_detected = (c == 0) || (c == rlast) || 1'($urandom);
        default: bus.miss_detected = 1'b1;
      endcase
      bus.miss_address      = (c == 0) ? a : 16'($urandom);
      bus.memory_data_valid = (kat[c] >= 0) || ((c == 0) && 1'($urandom));
      #1;
      exp_wr = (kat[c] >= 0);
      if (bus.fsm_busy) busy_cnt++;
      if (c == 1) first_req = bus.memory_address;
      if (c == W) last_req  = bus.memory_address;
      check("busy", 16'(bus.fsm_busy), 16'(c >= 1));
      check("req",  16'(bus.mem_req),  16'((c >= 1) && (c <= W)));
      if (c >= 1) check("maddr", bus.memory_address, m_addr(a, (c <= W) ? c - 1 : W - 1));
      check("wda",  16'(bus.write_data_array), 16'(exp_wr));
      if (exp_wr) check("waddr", bus.write_word_addr, m_addr(a, kat[c]));
      check("wta",  16'(bus.write_tag_array), 16'(c == rlast));
      if (stop > 0 && c == r[stop]) break;
    end
  endtask

  initial begin
    int          bc;
    logic [15:0] fr;
    logic [15:0] lr;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0;
    bus.memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Valids with no fill in progress must not write.
    idle_cycles(4, 1'b1);

    // Miss at 0x1236, latency 4.
    run_fill(16'h1236, 4, 0, 0, bc, fr, lr);
    check("busy_len_1236", 16'(bc), 16'd12);
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    check("first_1236", fr, 16'h1236);
    check("last_1236",  lr, 16'h1234);
`else
    check("first_1236", fr, 16'h1230);
    check("last_1236",  lr, 16'h123E);
`endif
    idle_cycles(2, 1'b0);

    // Top of address space: no carry out of the block.
    run_fill(16'hFFFE, 1, 1, 0, bc, fr, lr);
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
    check("first_fffe", fr, 16'hFFFE);
    check("last_fffe",  lr, 16'hFFFC);
`else
    check("first_fffe", fr, 16'hFFF0);
    check("last_fffe",  lr, 16'hFFFE);
`endif
    idle_cycles(2, 1'b0);

    // Reset after the third response abandons the fill.
    run_fill(16'h5A3C, 2, 0, 3, bc, fr, lr);
    @(negedge clk);
    rst_n                 = 1'b0;
    bus.miss_detected     = 1'b1;
    bus.memory_data_valid = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.miss_detected = 1'b0;
    #1;
    check("post_rst_wda", 16'(bus.write_data_array), 16'h0);
    idle_cycles(4, 1'b1);
    run_fill(16'h0040, 3, 0, 0, bc, fr, lr);
    check("busy_len_0040", 16'(bc), 16'd11);
    idle_cycles(1, 1'b0);

    // Miss held high: back-to-back fills, each one restarting from IDLE.
    run_fill(16'($urandom), 0, 2, 0, bc, fr, lr);
    run_fill(16'($urandom), 0, 2, 0, bc, fr, lr);
    run_fill(16'($urandom), 0, 1, 0, bc, fr, lr);
    idle_cycles(2, 1'b0);

    // Random addresses, latencies and gaps.
    for (int i = 0; i < 20; i++) begin
      run_fill(16'($urandom), (i % 3 == 0) ? 0 : int'($urandom_range(1, 6)), i % 2, 0, bc, fr, lr);
      idle_cycles(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL be parameterised by WORDS_PER_BLOCK, default 8, the number of 16-bit words per cache block (power of two).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port miss_detected, input, 1, a cache-miss indication from the CPU datapath.
REQ-005 The block SHALL have port miss_address, input, 16, the byte address of the missing access.
REQ-006 The block SHALL have port memory_data_valid, input, 1, marking one returned word from multi-cycle memory.
REQ-007 The block SHALL have port fsm_busy, output, 1, high while a fill is in progress; the CPU stalls its PC on it.
REQ-008 The block SHALL have port mem_req, output, 1, a memory read-request strobe.
REQ-009 The block SHALL have port memory_address, output, 16, the byte address of the current request.
REQ-010 The block SHALL have port write_data_array, output, 1, a data-array write enable for the returned word.
REQ-011 The block SHALL have port write_word_addr, output, 16, the byte address of the word being written.
REQ-012 The block SHALL have port write_tag_array, output, 1, a tag/valid write enable for the filled block.

Function
REQ-013 The block SHALL implement two states, IDLE and FILL.
REQ-014 In IDLE, when miss_detected=1 at a rising edge, the block SHALL latch base = miss_address with the low log2(WORDS_PER_BLOCK)+1 bits cleared, clear both counters and enter FILL.
REQ-015 fsm_busy SHALL equal (state==FILL) combinationally, so it rises the cycle after the miss is sampled.
REQ-016 In FILL, the block SHALL assert mem_req for exactly WORDS_PER_BLOCK consecutive cycles, one request per cycle, with memory_address = base + 2*order(issue_cnt), where issue_cnt increments each request cycle.
REQ-017 After the final request, mem_req SHALL be 0 and memory_address SHALL hold its last value.
REQ-018 In FILL, each cycle with memory_data_valid=1 SHALL assert write_data_array in the same cycle (combinational) with write_word_addr = base + 2*order(recv_cnt), and SHALL increment recv_cnt at the edge.
REQ-019 On the valid that carries word WORDS_PER_BLOCK-1 by count, the block SHALL also assert write_tag_array in that cycle and return to IDLE at the following edge.
REQ-020 The block SHALL tolerate response latency of 1 or more cycles, including valids that overlap ongoing requests.
REQ-021 A miss_detected in FILL SHALL be ignored, and a memory_data_valid in IDLE SHALL produce no write.
REQ-022 A miss_detected in the same cycle that write_tag_array is asserted SHALL NOT start a fill; a new fill starts only when the miss is sampled in IDLE.
REQ-023 Address arithmetic SHALL be 16-bit modulo; base+offset SHALL never carry outside the block.

Reset
REQ-024 While rst_n=0, the block SHALL be in IDLE with counters and base at 0 and all outputs at 0, regardless of clk.
REQ-025 A reset asserted mid-fill SHALL abandon the fill; no tag write occurs, and later valids are ignored until a new miss.

Configuration
REQ-026 With macro CACHE_FILL_CRITICAL_FIRST_EN defined, order(n) SHALL be (miss_word + n) mod WORDS_PER_BLOCK, where miss_word = miss_address[log2(WORDS_PER_BLOCK):1] latched at miss, so that the critical word is fetched first and order wraps at the block end.
REQ-027 Without CACHE_FILL_CRITICAL_FIRST_EN, order(n) SHALL be n, giving sequential fill from offset 0.

Verification
REQ-028 A bench SHALL cover: miss at 0x1236, 4-cycle latency, macro off -> requests at 0x1230..0x123E on 8 consecutive cycles, 8 writes in the same order, tag write on the 8th, busy high for 12 cycles.
REQ-029 A bench SHALL cover: the same stimulus with macro on -> request and write order 0x1236, 0x1238, 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234.
REQ-030 A bench SHALL cover: miss at 0xFFFE with macro off -> base 0xFFF0 and last address 0xFFFE, with no wrap to 0x0000.
REQ-031 A bench SHALL cover: rst_n pulsed low after the 3rd response -> all outputs 0 immediately; later valids produce no write; a subsequent miss at 0x0040 completes a normal fill.
REQ-032 A bench SHALL cover: miss_detected held high throughout and asserted again during FILL -> exactly one fill; the next fill's first request appears 2 cycles after the tag write.
REQ-033 A bench SHALL cover: memory_data_valid pulsed in IDLE -> write_data_array and write_tag_array stay 0.
